// File: rtl/riscv_dmem_pkg.sv
// Shared definitions for the data-memory responder: verdict encoding,
// store-log entry layout and a constant-foldable clog2 helper.
package riscv_dmem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned LOG_ENTRY_W = 64;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } log_entry_t;

  // Ceiling log2; clog2(1) = 0. Callers pass values >= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/store_log_fifo.sv
// Synchronous FIFO with a show-ahead head; pops of an empty FIFO are ignored
// and a push into a full FIFO is accepted only when a pop happens the same cycle.
module store_log_fifo
  import riscv_dmem_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head entry is presented directly; an empty FIFO shows zero.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/dmem_store_responder.sv
// Data-memory responder for the single-cycle core: word RAM with a
// combinational read port, store error flags, pass/fail/timeout verdict FSM
// and, when DMEM_STORE_LOG_EN is defined, a drainable log of RUN-state stores.
module dmem_store_responder
  import riscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 64,
  parameter int unsigned LOG_DEPTH      = 8,
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [1:0]  status,
  output logic        done,
  output logic        err_misaligned,
  output logic        err_range,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam int unsigned IDX_W       = clog2(DEPTH_WORDS);
  localparam int unsigned CYC_W       = clog2(TIMEOUT_CYCLES);
  localparam int unsigned RANGE_BYTES = DEPTH_WORDS * 4;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic             aligned;
  logic             in_range;
  logic             wr_en;
  logic             sig_hit;
  logic             timeout_hit;
  status_e          state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             err_mis_q, err_mis_d;
  logic             err_rng_q, err_rng_d;

  assign word_idx    = DataAddr[IDX_W+1:2];
  assign aligned     = (DataAddr[1:0] == 2'b00);
  assign in_range    = (DataAddr < 32'(RANGE_BYTES));
  assign wr_en       = MemWrite && aligned && in_range;
  assign sig_hit     = MemWrite && (DataAddr == PASS_ADDR);
  assign timeout_hit = (cyc_q == CYC_W'(TIMEOUT_CYCLES - 1));

  // Zero-latency load path; low address bits are ignored, out-of-range reads give 0.
  assign ReadData = in_range ? mem_q[word_idx] : '0;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[word_idx] <= WriteData;
  end

  // Verdict state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Verdict next state: signature store beats timeout; verdicts are terminal.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (sig_hit)          state_d = (WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
      else if (timeout_hit) state_d = ST_TIMEOUT;
    end
  end

  // Verdict outputs decoded from the state register.
  always_comb begin
    status = state_q;
    done   = (state_q != ST_RUN);
  end

  // Cycle counter and sticky error flag next state.
  always_comb begin
    cyc_d     = cyc_q;
    err_mis_d = err_mis_q | (MemWrite && !aligned);
    err_rng_d = err_rng_q | (MemWrite && !in_range);
    if ((state_q == ST_RUN) && !timeout_hit) cyc_d = cyc_q + CYC_W'(1);
  end

  // Counter and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q     <= '0;
      err_mis_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      err_mis_q <= err_mis_d;
      err_rng_q <= err_rng_d;
    end
  end

  assign err_misaligned = err_mis_q;
  assign err_range      = err_rng_q;

`ifdef DMEM_STORE_LOG_EN
  log_entry_t push_entry;
  log_entry_t head_entry;
  logic       fifo_full;
  logic       fifo_empty;
  logic       log_push;
  logic       log_pop;
  logic       ovf_q, ovf_d;

  assign log_push   = MemWrite && (state_q == ST_RUN);
  assign log_pop    = log_ready && !fifo_empty;
  assign push_entry = log_entry_t'{addr: DataAddr, data: WriteData};

  store_log_fifo #(
    .WIDTH (LOG_ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_store_log_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (log_push),
    .pop     (log_pop),
    .wr_data (push_entry),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Overflow records a store lost to a full FIFO with no simultaneous drain.
  always_comb begin
    ovf_d = ovf_q | (log_push && fifo_full && !log_pop);
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign log_valid    = !fifo_empty;
  assign log_addr     = head_entry.addr;
  assign log_data     = head_entry.data;
  assign log_overflow = ovf_q;
`else
  logic                  unused_log_ready;
  localparam int unsigned unused_log_depth = LOG_DEPTH;

  assign unused_log_ready = log_ready;
  assign log_valid        = 1'b0;
  assign log_addr         = '0;
  assign log_data         = '0;
  assign log_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_store_responder.sv
// Scoreboard bench for dmem_store_responder: a behavioural model predicts each
// cycle's outputs and the order of logged stores; a monitor checks them.
module tb_dmem_store_responder;

  localparam int unsigned DEPTH_WORDS = 64;
  localparam int          LOG_DEPTH   = 8;
  localparam int          TIMEOUT     = 64;
  localparam logic [31:0] PASS_ADDR   = 32'd100;
  localparam logic [31:0] PASS_DATA   = 32'd25;
  localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS * 4);
`ifdef DMEM_STORE_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [1:0]  status;
  logic        done;
  logic        err_misaligned;
  logic        err_range;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;

  always #5 clk = ~clk;

  dmem_store_responder #(
    .DEPTH_WORDS    (DEPTH_WORDS),
    .LOG_DEPTH      (LOG_DEPTH),
    .PASS_ADDR      (PASS_ADDR),
    .PASS_DATA      (PASS_DATA),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .MemWrite       (MemWrite),
    .DataAddr       (DataAddr),
    .WriteData      (WriteData),
    .ReadData       (ReadData),
    .status         (status),
    .done           (done),
    .err_misaligned (err_misaligned),
    .err_range      (err_range),
    .log_valid      (log_valid),
    .log_ready      (log_ready),
    .log_addr       (log_addr),
    .log_data       (log_data),
    .log_overflow   (log_overflow)
  );

  typedef struct {
    bit          chk;
    int          st;
    bit          errm;
    bit          errr;
    bit          ovf;
    bit          lvalid;
    bit          log_zero;
    bit          rd_known;
    logic [31:0] rd_val;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] exp_log[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_mem [int];
  logic [63:0] m_fifo[$];
  int          m_status = 0;
  int          m_edges  = 0;
  bit          m_errm   = 1'b0;
  bit          m_errr   = 1'b0;
  bit          m_ovf    = 1'b0;
  bit          m_init   = 1'b0;
  bit          m_fresh  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Effect of one rising edge on the model.
  task automatic model_edge(input bit rst, input bit we, input logic [31:0] a,
                            input logic [31:0] d, input bit rdy);
    bit pop;
    if (rst) begin
      m_status = 0;
      m_edges  = 0;
      m_errm   = 1'b0;
      m_errr   = 1'b0;
      m_ovf    = 1'b0;
      m_fifo.delete();
      exp_log.delete();
      m_init   = 1'b1;
      m_fresh  = 1'b1;
      return;
    end
    m_fresh = 1'b0;
    pop = (m_fifo.size() != 0) && rdy;
    if (we && a[1:0] == 2'b00 && a < RANGE_BYTES) m_mem[int'(a >> 2)] = d;
    if (we && a[1:0] != 2'b00) m_errm = 1'b1;
    if (we && a >= RANGE_BYTES) m_errr = 1'b1;
    if (LOG_EN && we && m_status == 0) begin
      if (m_fifo.size() < LOG_DEPTH || pop) begin
        m_fifo.push_back({a, d});
        exp_log.push_back({a, d});
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (m_status == 0) begin
      m_edges++;
      if (we && a == PASS_ADDR)  m_status = (d == PASS_DATA) ? 1 : 2;
      else if (m_edges >= TIMEOUT) m_status = 3;
    end
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, advance the model.
  task automatic cyc(input bit rst, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input bit rdy);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    MemWrite  = we;
    DataAddr  = a;
    WriteData = d;
    log_ready = rdy;
    e.chk      = m_init;
    e.st       = m_status;
    e.errm     = m_errm;
    e.errr     = m_errr;
    e.ovf      = m_ovf;
    e.lvalid   = (m_fifo.size() != 0);
    e.log_zero = !LOG_EN || m_fresh;
    e.rd_known = 1'b0;
    e.rd_val   = '0;
    if (a >= RANGE_BYTES) begin
      e.rd_known = 1'b1;
    end else if (m_mem.exists(int'(a >> 2))) begin
      e.rd_known = 1'b1;
      e.rd_val   = m_mem[int'(a >> 2)];
    end
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(rst, we, a, d, rdy);
  endtask

  task automatic rand_op(output bit we, output logic [31:0] a, output logic [31:0] d);
    int k;
    k  = $urandom_range(0, 99);
    we = 1'b1;
    d  = $urandom;
    if (k < 50)      a = 32'($urandom_range(0, 63)) << 2;
    else if (k < 62) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    else if (k < 72) a = RANGE_BYTES + 32'($urandom_range(0, 4095));
    else if (k < 75) begin
      a = PASS_ADDR;
      d = ($urandom_range(0, 1) != 0) ? PASS_DATA : 32'($urandom_range(0, 50));
    end else begin
      we = 1'b0;
      a  = 32'($urandom_range(0, 300));
    end
  endtask

  // Monitor: compare each cycle's outputs and every accepted log entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("status", 64'(status), 64'(e.st));
          check("done", 64'(done), 64'(e.st != 0));
          check("err_misaligned", 64'(err_misaligned), 64'(e.errm));
          check("err_range", 64'(err_range), 64'(e.errr));
          check("log_overflow", 64'(log_overflow), 64'(e.ovf));
          check("log_valid", 64'(log_valid), 64'(e.lvalid));
          if (e.rd_known) check("ReadData", 64'(ReadData), 64'(e.rd_val));
          if (e.log_zero) check("log_head_zero", {log_addr, log_data}, 64'd0);
        end
      end
      if (log_valid === 1'b1 && log_ready === 1'b1) begin
        if (exp_log.size() == 0) check("log_unexpected", {log_addr, log_data}, 64'hx);
        else                     check("log_entry", {log_addr, log_data}, exp_log.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    int          len;
    int          rdy_pct;

    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAddr  = '0;
    WriteData = '0;
    log_ready = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // Basic store/load, misaligned and out-of-range behaviour
    cyc(0, 1, 32'd8, 32'h1234, 0);
    cyc(0, 0, 32'd8, 0, 0);
    cyc(0, 1, 32'd4, 32'hAAAA5555, 0);
    cyc(0, 1, 32'd6, 32'hDEADBEEF, 0);
    cyc(0, 0, 32'd4, 0, 0);
    cyc(0, 0, 32'd6, 0, 0);
    cyc(0, 1, 32'd256, 32'hBEEF, 0);
    cyc(0, 0, 32'd256, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 32'd8, 0, 1);

    // Overflow, full push+pop, in-order drain
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 32'(16 + 4 * i), $urandom, 0);
    cyc(0, 1, 32'h40, 32'h77, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 32'd16, 0, 1);

    // PASS is terminal; FAIL on wrong signature data
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, PASS_ADDR, PASS_DATA, 1);
    cyc(0, 0, PASS_ADDR, 0, 1);
    cyc(0, 1, PASS_ADDR, 32'd7, 1);
    cyc(0, 0, PASS_ADDR, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, PASS_ADDR, 32'd7, 1);
    cyc(0, 0, 0, 0, 1);

    // Reset after logged stores and FAIL; RAM retained
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 32'd20, 32'h11, 0);
    cyc(0, 1, 32'd24, 32'h22, 0);
    cyc(0, 1, 32'd28, 32'h33, 0);
    cyc(0, 1, PASS_ADDR, 32'd7, 0);
    cyc(0, 0, 32'd20, 0, 0);
    cyc(1, 0, 32'd20, 0, 0);
    cyc(0, 0, 32'd24, 0, 0);
    cyc(0, 0, 32'd28, 0, 1);

    // Timeout with no stores, then a late signature is ignored
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) cyc(0, 0, 32'($urandom_range(0, 63)) << 2, 0, 1'($urandom_range(0, 1)));
    cyc(0, 1, PASS_ADDR, PASS_DATA, 0);
    cyc(0, 0, 0, 0, 0);

    // Signature store on the timeout edge wins
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, PASS_ADDR, PASS_DATA, 1);
    cyc(0, 0, 0, 0, 1);

    // Randomized segments
    for (int s = 0; s < 20; s++) begin
      cyc(1, 0, 0, 0, 0);
      len     = $urandom_range(10, 80);
      rdy_pct = $urandom_range(0, 100);
      for (int i = 0; i < len; i++) begin
        rand_op(we, a, d);
        cyc(0, we, a, d, $urandom_range(0, 99) < rdy_pct);
      end
    end

    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_store_responder.md
# dmem_store_responder

Responder end of the single-cycle core's data-memory write interface: consumes `MemWrite`/`DataAddr`/`WriteData` from `RISCV_single`, holds the word-addressed data RAM, and returns `ReadData`. It also watches the store stream for the program's pass/fail signature, and optionally logs every store into a drainable FIFO for board-level debug. It sits beside the processor inside the FPGA top, on the core's 20 MHz `clk_local` domain.

## Interface
- `DEPTH_WORDS`, 64: data RAM size in 32-bit words; must be a power of 2.
- `LOG_DEPTH`, 8: store-log FIFO entries; must be a power of 2 and at least 2.
- `PASS_ADDR`, 32'd100: byte address of the signature store.
- `PASS_DATA`, 32'd25: data value that signals pass.
- `TIMEOUT_CYCLES`, 1_000_000: cycle budget before the timeout verdict.
- `clk` input 1: core clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `MemWrite` input 1: store strobe from the core.
- `DataAddr` input 32: byte address, i.e. the ALU result.
- `WriteData` input 32: store data.
- `ReadData` output 32: combinational read of the addressed word.
- `status` output 2: verdict; 0 = RUN, 1 = PASS, 2 = FAIL, 3 = TIMEOUT.
- `done` output 1: high when `status` is not RUN.
- `err_misaligned` output 1: sticky; set by a store with `DataAddr[1:0]` != 0.
- `err_range` output 1: sticky; set by a store with `DataAddr` ≥ `DEPTH_WORDS`*4.
- `log_valid` output 1: FIFO non-empty.
- `log_ready` input 1: consumer accepts the head entry.
- `log_addr` output 32: head entry address.
- `log_data` output 32: head entry data.
- `log_overflow` output 1: sticky; a store was dropped because the FIFO was full.

## Operation
- **Reads.** `ReadData` = `mem[DataAddr[log2(DEPTH_WORDS)+1:2]]`, combinational, so a single-cycle load works.
  - Out-of-range read returns 0.
  - A misaligned read ignores the low 2 bits.
- **Stores.** A store is `MemWrite`=1 at a rising edge.
  - The store writes RAM only if it is aligned and in range.
  - A misaligned store sets `err_misaligned`. An out-of-range store sets `err_range`. Neither writes RAM.
  - RAM contents are not cleared by reset.
- **Verdict FSM** (RUN → PASS / FAIL / TIMEOUT):
  - In RUN, a store with `DataAddr`==`PASS_ADDR` and `WriteData`==`PASS_DATA` → PASS.
  - In RUN, a store with `DataAddr`==`PASS_ADDR` and any other data → FAIL.
  - The cycle counter reaching `TIMEOUT_CYCLES`-1 while in RUN → TIMEOUT.
  - If a signature store and timeout happen in the same cycle, the signature store wins.
  - PASS, FAIL and TIMEOUT are terminal until reset.
  - The RAM write from a signature store still occurs.
- **Log FIFO.**
  - Push: every store (aligned or not) while `status`==RUN pushes {`DataAddr`, `WriteData`}. Stores in terminal states are not logged.
  - Pop: `log_valid` && `log_ready`.
  - Ordering is strict FIFO, with a show-ahead head.
  - Full with no pop: the push is dropped and `log_overflow` is set.
  - Full with a pop in the same cycle: the push is accepted.
  - Empty with a push in the same cycle: `log_valid` rises next cycle, and `log_ready` that cycle is ignored.
  - Pointers wrap modulo `LOG_DEPTH`. Occupancy uses log2(`LOG_DEPTH`)+1 bits.

## Timing
- Reset values:
  - `status`=0, `done`=0.
  - `err_misaligned`=0, `err_range`=0, `log_overflow`=0.
  - `log_valid`=0, `log_addr`=0, `log_data`=0.
  - Cycle counter = 0, FIFO empty.
- Reset asserted mid-run: on the next edge all of the above clear and the FSM returns to RUN. The FIFO contents are discarded.
- Store → RAM visible on `ReadData`: next cycle.
- Store → `status`/`done` update: next cycle, so 1-cycle latency.
- Store → `log_valid`: next cycle.
- Error flags: set at the edge that samples the offending store.
- `ReadData` has zero-cycle latency.

## Configuration
- Macro `DMEM_STORE_LOG_EN`.
- Defined: the FIFO and log ports are implemented as above.
- Undefined: no FIFO storage is built. `log_valid`, `log_addr`, `log_data` and `log_overflow` are tied to 0, and `log_ready` is ignored. RAM, error flags and the verdict FSM are unchanged.

## Structure
- Shared package `riscv_dmem_pkg`:
  - The status encoding constants (`ST_RUN`, `ST_PASS`, `ST_FAIL`, `ST_TIMEOUT`).
  - The log entry width (64).
  - A `clog2` helper function.
- One sub-module, `store_log_fifo`:
  - Parameterized width/depth, synchronous FIFO with a show-ahead head.
  - Exposes `full`, `empty`, `push`, `pop`.
  - Instantiated only under `DMEM_STORE_LOG_EN`.

## Test plan
- Store 0x1234 to addr 8, then read addr 8 → `ReadData`=0x1234 next cycle; `status`=RUN.
- Store 25 to addr 100 → `status`=PASS and `done`=1 next cycle; a later store 7 to addr 100 leaves PASS unchanged.
- Store 7 to addr 100 → FAIL. Separately, with `TIMEOUT_CYCLES`=16 and no stores → TIMEOUT after cycle 15.
- Store to addr 6 → `err_misaligned`=1 and RAM word 1 unchanged. Store to addr 256 (DEPTH 64) → `err_range`=1 and `ReadData`=0.
- 9 stores with `log_ready`=0 (LOG_DEPTH 8) → `log_overflow`=1, and 8 entries drain in order. Full FIFO plus a simultaneous pop and push → occupancy stays 8 and the new entry is the tail.
- Reset after 3 logged stores and FAIL → all outputs at reset values next cycle, and RAM data is retained.
